mem_access_ctrl: RTL

//  Sequences MEM-stage data-memory accesses over a req/ack data bus.

---
 rtl/riscvx_mem_pkg.sv | 27 ++
 rtl/mem_load_align.sv | 36 +++
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/riscvx_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller.
// Holds funct3 width/sign codes, FSM state encoding and the alignment helper.
package riscvx_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // Low address bits with halfword/word accesses snapped to natural alignment.
  // An access is misaligned exactly when this changes the bits.
  function automatic logic [1:0] align_lo(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3)
      F3_H, F3_HU: return {a[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return a;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension of a 32-bit bus read word.
// Purely combinational; undefined funct3 codes return zero.
module mem_load_align
  import riscvx_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (a)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];

    data = '0;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: IDLE -> REQ -> DONE over a req/ack bus.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of forcing alignment.
module mem_access_ctrl
  import riscvx_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_MEM,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  output logic        stall_MEM,
  output logic [31:0] mem_data_MEM,
  output logic        bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_trap,
`endif
  output logic [1:0]  state_dbg,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  // Bus handshake: dbus_req is high for every REQ cycle and we/addr/be/wdata stay
  // stable until the cycle dbus_ack is sampled high; ack in any other state is
  // ignored, and reset withdraws req at once without waiting for an ack.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        a_lo, a_lo_q;
  logic [2:0]        f3_q;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       load_data;
  logic              acc, misaligned, issue, trap_start, timeout;

  assign acc       = valid_MEM & (memread_MEM | memwrite_MEM);
  assign a_lo      = align_lo(funct3_MEM, addr_MEM[1:0]);
  assign timeout   = (cnt_q == CNT_LAST) & ~dbus_ack;
  assign state_dbg = state_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (a_lo != addr_MEM[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Width comes from funct3[1:0] so loads and stores share the lane decode.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = wdata_MEM;
    case (funct3_MEM[1:0])
      2'b00: begin
        be_d    = 4'b0001 << a_lo;
        wdata_d = {4{wdata_MEM[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {a_lo[1], 1'b0};
        wdata_d = {2{wdata_MEM[15:0]}};
      end
      2'b10:   be_d = 4'hF;
      default: be_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stall_MEM  = 1'b0;
    dbus_req   = 1'b0;
    issue      = 1'b0;
    trap_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_MEM = acc;
        if (acc) begin
          if (misaligned) begin
            state_d    = ST_DONE;
            trap_start = 1'b1;
          end else begin
            state_d = ST_REQ;
            issue   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_MEM = 1'b1;
        dbus_req  = 1'b1;
        if (dbus_ack || timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_be      <= '0;
      dbus_wdata   <= '0;
      mem_data_MEM <= '0;
      bus_err      <= 1'b0;
      cnt_q        <= '0;
      a_lo_q       <= '0;
      f3_q         <= '0;
    end else begin
      bus_err <= 1'b0;
      if (issue) begin
        dbus_we    <= memwrite_MEM;
        dbus_addr  <= {addr_MEM[31:2], 2'b00};
        dbus_be    <= be_d;
        dbus_wdata <= wdata_d;
        a_lo_q     <= a_lo;
        f3_q       <= funct3_MEM;
      end
      if (trap_start) mem_data_MEM <= '0;
      if (state_q == ST_REQ) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (dbus_ack) begin
          mem_data_MEM <= dbus_we ? 32'h0 : load_data;
        end else if (timeout) begin
          mem_data_MEM <= '0;
          bus_err      <= 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_trap <= 1'b0;
    else       misalign_trap <= trap_start;
  end
`endif

  mem_load_align u_load_align (
    .rdata  (dbus_rdata),
    .a      (a_lo_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

endmodule
